// File: rtl/gpio_defs_pkg.sv
// Shared GPIO definitions: switch count, debounce defaults and debounce state encoding.
package gpio_defs;

    localparam int unsigned GPIO_NUM_SW                  = 16;
    localparam int unsigned GPIO_DB_SYNC_STAGES_DEFAULT  = 2;
    localparam int unsigned GPIO_DB_TICK_DIV_DEFAULT     = 50000;
    localparam int unsigned GPIO_DB_STABLE_TICKS_DEFAULT = 10;

    typedef enum logic {
        DB_IDLE,
        DB_COUNT
    } type_db_state_e;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int unsigned db_cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_db_cell.sv
// One switch bit: synchroniser chain, IDLE/COUNT debounce FSM and stability counter.
module gpio_db_cell
    import gpio_defs::*;
#(
    parameter int unsigned SYNC_STAGES  = GPIO_DB_SYNC_STAGES_DEFAULT,
    parameter int unsigned STABLE_TICKS = GPIO_DB_STABLE_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic change
);

    localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    type_db_state_e         state;
    logic [CW-1:0]          cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // level and change are both registered here, so change is high exactly
    // in the first cycle the new level is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= DB_IDLE;
            cnt    <= '0;
            level  <= 1'b0;
            change <= 1'b0;
        end else begin
            change <= 1'b0;
            if (tick) begin
                case (state)
                    DB_IDLE: begin
                        if (sync != level) begin
                            if (STABLE_TICKS == 1) begin
                                level  <= ~level;
                                change <= 1'b1;
                            end else begin
                                cnt   <= CW'(1);
                                state <= DB_COUNT;
                            end
                        end
                    end
                    DB_COUNT: begin
                        if (sync == level) begin
                            cnt   <= '0;
                            state <= DB_IDLE;
                        end else if (cnt == CNT_LAST) begin
                            level  <= ~level;
                            change <= 1'b1;
                            cnt    <= '0;
                            state  <= DB_IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= DB_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/gpio_sw_debounce.sv
// Switch input conditioning: per-bit debounce cells sharing one sample-tick prescaler.
// Optional sticky pending flags and IRQ are enabled by defining GPIO_DEBOUNCE_IRQ_EN.
module gpio_sw_debounce
    import gpio_defs::*;
#(
    parameter int unsigned NUM_SW       = GPIO_NUM_SW,
    parameter int unsigned SYNC_STAGES  = GPIO_DB_SYNC_STAGES_DEFAULT,
    parameter int unsigned TICK_DIV     = GPIO_DB_TICK_DIV_DEFAULT,
    parameter int unsigned STABLE_TICKS = GPIO_DB_STABLE_TICKS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] gp_switch_raw_i,
    output logic [NUM_SW-1:0] gp_switch_o,
    output logic [NUM_SW-1:0] sw_change_o,
    input  logic [NUM_SW-1:0] sw_clr_i,
    output logic [NUM_SW-1:0] sw_pending_o,
    output logic              sw_irq_o
);

    localparam int unsigned TW = db_cnt_width(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt;
    logic          tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    for (genvar i = 0; i < NUM_SW; i++) begin : g_cell
        gpio_db_cell #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS)
        ) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick   (tick),
            .raw    (gp_switch_raw_i[i]),
            .level  (gp_switch_o[i]),
            .change (sw_change_o[i])
        );
    end

`ifdef GPIO_DEBOUNCE_IRQ_EN
    logic [NUM_SW-1:0] pending_q;
    logic [NUM_SW-1:0] pending_d;
    logic              irq_q;

    // Set term is OR'd after the clear so a coincident change wins.
    always_comb begin
        pending_d = (pending_q & ~sw_clr_i) | sw_change_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            irq_q     <= |pending_d;
        end
    end

    assign sw_pending_o = pending_q;
    assign sw_irq_o     = irq_q;
`else
    logic unused_clr;
    assign unused_clr   = ^sw_clr_i;
    assign sw_pending_o = '0;
    assign sw_irq_o     = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_sw_debounce.sv
// Directed bench for gpio_sw_debounce with TICK_DIV=4, STABLE_TICKS=3.
module tb_gpio_sw_debounce;

    logic        clk;
    logic        rst_n;
    logic [15:0] raw;
    logic [15:0] clr;
    logic [15:0] gp_switch;
    logic [15:0] sw_change;
    logic [15:0] sw_pending;
    logic        sw_irq;

    int          checks;
    int          failures;
    int          cyc;
    int          chg_cycles;
    int          last_chg_cyc;
    logic [15:0] last_chg;
    int          e;
    int          c;

    gpio_sw_debounce #(
        .NUM_SW       (16),
        .SYNC_STAGES  (2),
        .TICK_DIV     (4),
        .STABLE_TICKS (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .gp_switch_raw_i (raw),
        .gp_switch_o     (gp_switch),
        .sw_change_o     (sw_change),
        .sw_clr_i        (clr),
        .sw_pending_o    (sw_pending),
        .sw_irq_o        (sw_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (sw_change != 16'h0000) begin
            chg_cycles++;
            last_chg     = sw_change;
            last_chg_cyc = cyc;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_acc();
        chg_cycles   = 0;
        last_chg     = 16'h0000;
        last_chg_cyc = -1;
    endtask

    // Raw driven just after edge ee is first seen by the FSM at edge ee+3;
    // ticks fall on edges that are multiples of 4 after reset release.
    function automatic int commit_at(input int ee);
        int t;
        t = ee + 3;
        while ((t % 4) != 0) t++;
        return t + 8;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        raw      = 16'hFFFF;
        clr      = 16'h0000;
        clear_acc();

        // Reset with all switches high
        steps(3);
        check_eq("rst_gp", gp_switch, 16'h0000);
        check_eq("rst_chg", sw_change, 16'h0000);
        check_eq("rst_pend", sw_pending, 16'h0000);
        check_eq("rst_irq", sw_irq, 1'b0);
        rst_n = 1'b1;
        cyc   = 0;
        clear_acc();
        steps(11);
        check_eq("rel_gp_early", gp_switch, 16'h0000);
        step();
        check_eq("rel_gp", gp_switch, 16'hFFFF);
        check_eq("rel_chg", sw_change, 16'hFFFF);
        step();
        check_eq("rel_chg_drop", sw_change, 16'h0000);
        check_eq("rel_pulses", chg_cycles, 1);

        clr = 16'hFFFF;
        step();
        clr = 16'h0000;
        raw = 16'h0000;
        steps(20);
        check_eq("all_low", gp_switch, 16'h0000);

        // Single bit rise
        clear_acc();
        e   = cyc;
        raw = 16'h0008;
        steps(20);
        check_eq("b3_gp", gp_switch, 16'h0008);
        check_eq("b3_pulses", chg_cycles, 1);
        check_eq("b3_chg", last_chg, 16'h0008);
        check_eq("b3_when", last_chg_cyc, commit_at(e));
        check_eq("b3_window", {31'b0, (last_chg_cyc - e >= 11) && (last_chg_cyc - e <= 14)}, 1);

        // Short glitch is rejected
        clear_acc();
        raw = 16'h0028;
        steps(6);
        raw = 16'h0008;
        steps(30);
        check_eq("b5_gp", gp_switch, 16'h0008);
        check_eq("b5_pulses", chg_cycles, 0);

        // Two bits committing together
        clear_acc();
        e   = cyc;
        raw = 16'h8009;
        steps(20);
        check_eq("b0b15_gp", gp_switch, 16'h8009);
        check_eq("b0b15_pulses", chg_cycles, 1);
        check_eq("b0b15_chg", last_chg, 16'h8001);
        check_eq("b0b15_when", last_chg_cyc, commit_at(e));

`ifdef GPIO_DEBOUNCE_IRQ_EN
        clr = 16'hFFFF;
        step();
        clr = 16'h0000;
        step();
        check_eq("irq_clr_all_pend", sw_pending, 16'h0000);
        check_eq("irq_clr_all_irq", sw_irq, 1'b0);

        clear_acc();
        raw = 16'h800D;
        steps(20);
        check_eq("irq_b2_pend", sw_pending, 16'h0004);
        check_eq("irq_b2_irq", sw_irq, 1'b1);

        clr = 16'h0004;
        step();
        clr = 16'h0000;
        check_eq("irq_b2_clr_pend", sw_pending, 16'h0000);
        check_eq("irq_b2_clr_irq", sw_irq, 1'b0);

        e   = cyc;
        raw = 16'h8009;
        c   = commit_at(e);
        steps(c - cyc);
        check_eq("irq_coin_pulse", sw_change, 16'h0004);
        clr = 16'h0004;
        step();
        clr = 16'h0000;
        check_eq("irq_coin_pend", sw_pending, 16'h0004);
        check_eq("irq_coin_irq", sw_irq, 1'b1);
`else
        clr = 16'hFFFF;
        step();
        check_eq("noirq_pend", sw_pending, 16'h0000);
        check_eq("noirq_irq", sw_irq, 1'b0);
        clr = 16'h0000;
`endif

        // Reset mid-count on bit 7
        raw = raw | 16'h0080;
        steps(9);
        check_eq("mid_gp7_pre", gp_switch[7], 1'b0);
        rst_n = 1'b0;
        steps(2);
        check_eq("mid_rst_gp", gp_switch, 16'h0000);
        check_eq("mid_rst_pend", sw_pending, 16'h0000);
        rst_n = 1'b1;
        cyc   = 0;
        clear_acc();
        steps(11);
        check_eq("mid_gp_early", gp_switch, 16'h0000);
        check_eq("mid_no_pulse", chg_cycles, 0);
        step();
        check_eq("mid_gp", gp_switch, raw);
        check_eq("mid_chg", sw_change, raw);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
